// File: rtl/ysyx_25020037_exu_pipe.sv
// Execute-stage output register: 2-entry result queue toward LSU/WBU plus branch/jump redirect pulse.
// Optional perf counters are enabled by defining YSYX_25020037_EXU_PERF_EN.
module ysyx_25020037_exu_pipe (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_wen,
  input  logic        in_is_branch,
  input  logic        in_is_jal,
  input  logic        in_is_jalr,
  input  logic        in_mem_ren,
  input  logic        in_mem_wen,
  input  logic [1:0]  in_mem_size,
  input  logic [31:0] in_store_data,
  input  logic [31:0] alu_result1,
  input  logic [31:0] alu_result2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rd,
  output logic        out_rd_wen,
  output logic        out_mem_ren,
  output logic        out_mem_wen,
  output logic [1:0]  out_mem_size,
  output logic [31:0] out_store_data,
  output logic [31:0] out_wdata,
  output logic [31:0] out_addr,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] perf_issue_cnt,
  output logic [31:0] perf_redirect_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        mem_ren;
    logic        mem_wen;
    logic [1:0]  mem_size;
    logic [31:0] store_data;
    logic [31:0] wdata;
    logic [31:0] addr;
  } entry_t;

  logic [1:0]  r_count;
  logic        r_wptr;
  logic        r_rptr;
  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;

  logic        w_enq;
  logic        w_deq;
  logic        w_taken;
  logic [31:0] w_redir_pc;
  entry_t      w_new;
  entry_t      w_head;
  entry_t      w_ents [2];
  logic        w_unused;

  // Only the condition bit of the second ALU result matters.
  assign w_unused = ^alu_result2[31:1];

  assign in_ready  = (r_count != 2'd2) & ~r_redirect_valid;
  assign out_valid = (r_count != 2'd0);
  assign w_enq     = in_valid & in_ready;
  assign w_deq     = out_valid & out_ready;
  assign w_taken   = in_is_jal | in_is_jalr | (in_is_branch & alu_result2[0]);
  assign w_redir_pc = in_is_jalr ? {alu_result1[31:1], 1'b0} : alu_result1;

  always_comb begin
    w_new            = '0;
    w_new.pc         = in_pc;
    w_new.rd         = in_rd;
    w_new.rd_wen     = in_rd_wen & (in_rd != 5'd0) & ~in_is_branch;
    w_new.mem_ren    = in_mem_ren;
    w_new.mem_wen    = in_mem_wen;
    w_new.mem_size   = in_mem_size;
    w_new.store_data = in_store_data;
    w_new.wdata      = (in_is_jal | in_is_jalr) ? (in_pc + 32'd4) : alu_result1;
    w_new.addr       = alu_result1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      entry_t r_ent;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_ent <= '0;
        end else if (w_enq && (r_wptr == 1'(gi))) begin
          r_ent <= w_new;
        end
      end
      assign w_ents[gi] = r_ent;
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= 2'd0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else begin
      if (w_enq) r_wptr <= ~r_wptr;
      if (w_deq) r_rptr <= ~r_rptr;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Redirect is a single-cycle pulse; the pc register holds its last value otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
    end else begin
      r_redirect_valid <= w_enq & w_taken;
      if (w_enq && w_taken) r_redirect_pc <= w_redir_pc;
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

  assign w_head         = r_rptr ? w_ents[1] : w_ents[0];
  assign out_pc         = w_head.pc;
  assign out_rd         = w_head.rd;
  assign out_rd_wen     = w_head.rd_wen;
  assign out_mem_ren    = w_head.mem_ren;
  assign out_mem_wen    = w_head.mem_wen;
  assign out_mem_size   = w_head.mem_size;
  assign out_store_data = w_head.store_data;
  assign out_wdata      = w_head.wdata;
  assign out_addr       = w_head.addr;

`ifdef YSYX_25020037_EXU_PERF_EN
  logic [31:0] r_issue_cnt;
  logic [31:0] r_redir_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_issue_cnt <= 32'd0;
      r_redir_cnt <= 32'd0;
    end else begin
      if (w_enq)            r_issue_cnt <= r_issue_cnt + 32'd1;
      if (r_redirect_valid) r_redir_cnt <= r_redir_cnt + 32'd1;
    end
  end

  assign perf_issue_cnt    = r_issue_cnt;
  assign perf_redirect_cnt = r_redir_cnt;
`else
  assign perf_issue_cnt    = 32'd0;
  assign perf_redirect_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ysyx_25020037_exu_pipe.sv
// Scoreboard bench for ysyx_25020037_exu_pipe: driver pushes expected entries, monitor compares heads.
module tb_ysyx_25020037_exu_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [4:0]  in_rd = '0;
  logic        in_rd_wen = 1'b0;
  logic        in_is_branch = 1'b0;
  logic        in_is_jal = 1'b0;
  logic        in_is_jalr = 1'b0;
  logic        in_mem_ren = 1'b0;
  logic        in_mem_wen = 1'b0;
  logic [1:0]  in_mem_size = '0;
  logic [31:0] in_store_data = '0;
  logic [31:0] alu_result1 = '0;
  logic [31:0] alu_result2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic        out_mem_ren;
  logic        out_mem_wen;
  logic [1:0]  out_mem_size;
  logic [31:0] out_store_data;
  logic [31:0] out_wdata;
  logic [31:0] out_addr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_redirect_cnt;

  ysyx_25020037_exu_pipe dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
    .in_rd_wen(in_rd_wen), .in_is_branch(in_is_branch), .in_is_jal(in_is_jal),
    .in_is_jalr(in_is_jalr), .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen),
    .in_mem_size(in_mem_size), .in_store_data(in_store_data),
    .alu_result1(alu_result1), .alu_result2(alu_result2),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
    .out_rd_wen(out_rd_wen), .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen),
    .out_mem_size(out_mem_size), .out_store_data(out_store_data),
    .out_wdata(out_wdata), .out_addr(out_addr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .perf_issue_cnt(perf_issue_cnt), .perf_redirect_cnt(perf_redirect_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        mem_ren;
    logic        mem_wen;
    logic [1:0]  mem_size;
    logic [31:0] store_data;
    logic [31:0] wdata;
    logic [31:0] addr;
  } ent_t;

  ent_t        sb[$];
  ent_t        dut_ent;
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;
  bit          mdl_ready = 1'b0;
  bit          exp_rv = 1'b0;
  logic [31:0] exp_rpc = '0;
  int unsigned exp_issue = 0;
  int unsigned exp_redir = 0;
  bit          acc;

  assign dut_ent = {out_pc, out_rd, out_rd_wen, out_mem_ren, out_mem_wen, out_mem_size,
                    out_store_data, out_wdata, out_addr};

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_perf_issue();
`ifdef YSYX_25020037_EXU_PERF_EN
    return exp_issue;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_perf_redir();
`ifdef YSYX_25020037_EXU_PERF_EN
    return exp_redir;
`else
    return 32'd0;
`endif
  endfunction

  // Monitor: runs at the falling edge, before the driver samples acceptance.
  always @(negedge clock) begin
    if (mon_en) begin
      mdl_ready = (sb.size() != 2) && !exp_rv;
      check("in_ready", 256'(in_ready), 256'(mdl_ready));
      check("out_valid", 256'(out_valid), 256'(sb.size() != 0));
      check("redirect_valid", 256'(redirect_valid), 256'(exp_rv));
      if (exp_rv) check("redirect_pc", 256'(redirect_pc), 256'(exp_rpc));
      check("perf_issue", 256'(perf_issue_cnt), 256'(exp_perf_issue()));
      check("perf_redirect", 256'(perf_redirect_cnt), 256'(exp_perf_redir()));
      if (out_valid && sb.size() != 0) begin
        check("head", 256'(dut_ent), 256'(sb[0]));
        if (out_ready) begin
          $display("deq pc=%08h rd=%0d wen=%0b wdata=%08h addr=%08h", out_pc, out_rd, out_rd_wen,
                   out_wdata, out_addr);
          void'(sb.pop_front());
        end
      end
      if (exp_rv) exp_redir++;
    end
  end

  // One clock cycle: decide acceptance from the model, record the expected entry and redirect.
  task automatic step();
    ent_t e;
    bit   taken;
    @(negedge clock);
    #2;
    acc = in_valid && mdl_ready;
    taken = in_is_jal || in_is_jalr || (in_is_branch && alu_result2[0]);
    if (acc) begin
      e.pc         = in_pc;
      e.rd         = in_rd;
      e.rd_wen     = in_rd_wen && (in_rd != 0) && !in_is_branch;
      e.mem_ren    = in_mem_ren;
      e.mem_wen    = in_mem_wen;
      e.mem_size   = in_mem_size;
      e.store_data = in_store_data;
      e.wdata      = (in_is_jal || in_is_jalr) ? in_pc + 32'd4 : alu_result1;
      e.addr       = alu_result1;
      sb.push_back(e);
      exp_issue++;
      if (taken) exp_rpc = in_is_jalr ? (alu_result1 & 32'hFFFF_FFFE) : alu_result1;
    end
    exp_rv = acc && taken;
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                        input logic wen, input logic br, input logic jal, input logic jalr,
                        input logic [31:0] r1, input logic [31:0] r2);
    in_valid = v; in_pc = pc; in_rd = rd; in_rd_wen = wen;
    in_is_branch = br; in_is_jal = jal; in_is_jalr = jalr;
    in_mem_ren = 1'b0; in_mem_wen = 1'b0; in_mem_size = 2'd2;
    in_store_data = $urandom; alu_result1 = r1; alu_result2 = r2;
  endtask

  // Hold the instruction until accepted, with a bounded wait.
  task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                       input logic br, input logic jal, input logic jalr,
                       input logic [31:0] r1, input logic [31:0] r2);
    int n;
    set_in(1'b1, pc, rd, wen, br, jal, jalr, r1, r2);
    n = 0;
    do begin
      step();
      n++;
    end while (!acc && n < 10);
    check("accept_bound", 256'(acc), 256'(1));
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_redirect", 256'(redirect_valid), 256'(0));
    check("rst_in_ready", 256'(in_ready), 256'(1));
    check("rst_perf_issue", 256'(perf_issue_cnt), 256'(0));
    check("rst_perf_redir", 256'(perf_redirect_cnt), 256'(0));
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    exp_rv = 1'b0; exp_issue = 0; exp_redir = 0;
    @(posedge clock);
    #1;
    mon_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    @(posedge clock);
    #1;
    do_reset();

    // ADD stream, one per cycle
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 32'h8000_0000 + 32'(4 * k), 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h5, 32'h0);
      step();
      check("add_accept", 256'(acc), 256'(1));
    end
    in_valid = 1'b0;
    step();

    // Backpressure: two fill the queue, the third waits for a dequeue
    out_ready = 1'b0;
    issue(32'h100, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11, 32'h0);
    issue(32'h104, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h22, 32'h0);
    set_in(1'b1, 32'h108, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h33, 32'h0);
    repeat (3) step();
    out_ready = 1'b1;
    issue(32'h108, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h33, 32'h0);
    repeat (3) step();

    // Branches taken / not taken, JALR with rd=1 and rd=0, JAL at the pc wrap point
    issue(32'h8000_0000, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0040, 32'h1);
    issue(32'h8000_0004, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0040, 32'h0);
    issue(32'h8000_0010, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0101, 32'h0);
    issue(32'h8000_0010, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0101, 32'h0);
    issue(32'hFFFF_FFFC, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0);
    issue(32'h0000_1000, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0);
    repeat (3) step();

    // Reset mid-stream with two entries queued and a redirect pulse in flight
    out_ready = 1'b0;
    issue(32'h200, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0);
    issue(32'h204, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0);
    do_reset();
    step();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      int kind;
      kind = $urandom_range(0, 5);
      set_in($urandom_range(0, 9) < 7, $urandom, 5'($urandom), 1'($urandom), kind == 1,
             kind == 2, kind == 3, $urandom, $urandom);
      in_mem_ren  = (kind == 4);
      in_mem_wen  = (kind == 5);
      in_mem_size = 2'($urandom_range(0, 2));
      out_ready   = $urandom_range(0, 3) != 0;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("drained", 256'(sb.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
